custom_ip_regbank: RTL and testbench

Parametrised register-to-hardware bridge between the SoC register file and a custom accelerator. It provides NUM_CH independent write channels, each with a four-phase req/ack handshake, so every write is captured exactly once and the channel can be rearmed. The read side takes snapshots of hardware status, periodically or on request, and raises per-channel change flags toward the register file.

---
 rtl/custom_ip_regbank.sv | 139 +++++++++++++
 tb/tb_custom_ip_regbank.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/custom_ip_regbank.sv
// Register-to-hardware bridge: per-channel four-phase write capture plus periodic/manual status snapshots.
// Optional build macro CUSTOM_IP_REGBANK_LOOPBACK_EN snapshots ch_data_o instead of hw_status_i.
module custom_ip_regbank #(
    parameter int unsigned NUM_CH      = 3,
    parameter int unsigned CH_WIDTH    = 32,
    parameter int unsigned SNAP_PERIOD = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [NUM_CH*CH_WIDTH-1:0]   reg2ip_data,
    input  logic [NUM_CH-1:0]            reg2ip_req,
    output logic [NUM_CH-1:0]            reg2ip_ack,
    output logic [NUM_CH*CH_WIDTH-1:0]   ch_data_o,
    input  logic [NUM_CH*CH_WIDTH-1:0]   hw_status_i,
    input  logic                         snap_req_i,
    output logic [NUM_CH*CH_WIDTH-1:0]   ip2reg_data,
    output logic [NUM_CH-1:0]            ip2reg_en
);
    localparam int unsigned DW = NUM_CH * CH_WIDTH;

    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_ACK  = 1'b1
    } ch_state_e;

    ch_state_e       ch_state_q [NUM_CH];
    ch_state_e       ch_state_d [NUM_CH];
    logic [DW-1:0]   ch_data_q, ch_data_d;

    // Handshake: a write is taken when req is seen high in IDLE; ack stays high until req is seen low.
    always_comb begin
        ch_data_d = ch_data_q;
        for (int k = 0; k < NUM_CH; k++) begin
            ch_state_d[k] = ch_state_q[k];
            case (ch_state_q[k])
                CH_IDLE: begin
                    if (reg2ip_req[k]) begin
                        ch_data_d[k*CH_WIDTH +: CH_WIDTH] = reg2ip_data[k*CH_WIDTH +: CH_WIDTH];
                        ch_state_d[k] = CH_ACK;
                    end
                end
                CH_ACK: begin
                    if (!reg2ip_req[k]) begin
                        ch_state_d[k] = CH_IDLE;
                    end
                end
                default: ch_state_d[k] = CH_IDLE;
            endcase
        end
    end

    always_comb begin
        reg2ip_ack = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            reg2ip_ack[k] = (ch_state_q[k] == CH_ACK);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < NUM_CH; k++) begin
                ch_state_q[k] <= CH_IDLE;
            end
            ch_data_q <= '0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                ch_state_q[k] <= ch_state_d[k];
            end
            ch_data_q <= ch_data_d;
        end
    end

    logic auto_trig;

    if (SNAP_PERIOD > 0) begin : g_period
        localparam int unsigned CW = (SNAP_PERIOD > 1) ? $clog2(SNAP_PERIOD) : 1;
        localparam logic [CW-1:0] LAST = CW'(SNAP_PERIOD - 1);

        logic [CW-1:0] cnt_q, cnt_d;

        // Free-running; manual strobes never disturb it.
        always_comb begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign auto_trig = (cnt_q == LAST);
    end else begin : g_no_period
        assign auto_trig = 1'b0;
    end

    logic          snap_trig;
    logic [DW-1:0] snap_src;
    logic [DW-1:0] snap_data_q, snap_data_d;
    logic [NUM_CH-1:0] snap_en_q, snap_en_d;

    assign snap_trig = snap_req_i | auto_trig;

`ifdef CUSTOM_IP_REGBANK_LOOPBACK_EN
    logic unused_hw_status;
    assign unused_hw_status = ^hw_status_i;
    assign snap_src = ch_data_q;
`else
    assign snap_src = hw_status_i;
`endif

    always_comb begin
        snap_data_d = snap_data_q;
        snap_en_d   = '0;
        if (snap_trig) begin
            snap_data_d = snap_src;
            for (int k = 0; k < NUM_CH; k++) begin
                snap_en_d[k] = (snap_src[k*CH_WIDTH +: CH_WIDTH] != snap_data_q[k*CH_WIDTH +: CH_WIDTH]);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            snap_data_q <= '0;
            snap_en_q   <= '0;
        end else begin
            snap_data_q <= snap_data_d;
            snap_en_q   <= snap_en_d;
        end
    end

    assign ch_data_o   = ch_data_q;
    assign ip2reg_data = snap_data_q;
    assign ip2reg_en   = snap_en_q;

endmodule

// File: tb/tb_custom_ip_regbank.sv
// Bench for custom_ip_regbank: directed vector table, hand-written corner sequences and a random phase
// checked every cycle against a behavioural model.
module tb_custom_ip_regbank;
    localparam int NUM_CH      = 3;
    localparam int CH_WIDTH    = 32;
    localparam int SNAP_PERIOD = 16;
    localparam int DW          = NUM_CH * CH_WIDTH;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic [DW-1:0]     reg2ip_data = '0;
    logic [NUM_CH-1:0] reg2ip_req = '0;
    logic [NUM_CH-1:0] reg2ip_ack;
    logic [DW-1:0]     ch_data_o;
    logic [DW-1:0]     hw_status_i = '0;
    logic              snap_req_i = 1'b0;
    logic [DW-1:0]     ip2reg_data;
    logic [NUM_CH-1:0] ip2reg_en;

    custom_ip_regbank #(
        .NUM_CH(NUM_CH), .CH_WIDTH(CH_WIDTH), .SNAP_PERIOD(SNAP_PERIOD)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .reg2ip_data(reg2ip_data), .reg2ip_req(reg2ip_req), .reg2ip_ack(reg2ip_ack),
        .ch_data_o(ch_data_o), .hw_status_i(hw_status_i), .snap_req_i(snap_req_i),
        .ip2reg_data(ip2reg_data), .ip2reg_en(ip2reg_en)
    );

    always #5 clk_i = ~clk_i;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Behavioural model: cycles since reset, per-channel "write outstanding" flags, captured words.
    int                cyc;
    logic [NUM_CH-1:0] m_busy;
    logic [DW-1:0]     m_data;
    logic [DW-1:0]     m_snap;
    logic [NUM_CH-1:0] m_en;

    task automatic model_reset();
        cyc = 0; m_busy = '0; m_data = '0; m_snap = '0; m_en = '0;
    endtask

    task automatic model_edge();
        logic [DW-1:0] src;
        bit trig;
        cyc++;
        trig = snap_req_i || (cyc % SNAP_PERIOD == 0);
`ifdef CUSTOM_IP_REGBANK_LOOPBACK_EN
        src = m_data;
`else
        src = hw_status_i;
`endif
        m_en = '0;
        if (trig) begin
            for (int k = 0; k < NUM_CH; k++)
                m_en[k] = (src[k*CH_WIDTH +: CH_WIDTH] != m_snap[k*CH_WIDTH +: CH_WIDTH]);
            m_snap = src;
        end
        for (int k = 0; k < NUM_CH; k++) begin
            if (!m_busy[k] && reg2ip_req[k]) begin
                m_data[k*CH_WIDTH +: CH_WIDTH] = reg2ip_data[k*CH_WIDTH +: CH_WIDTH];
                m_busy[k] = 1'b1;
            end else if (m_busy[k] && !reg2ip_req[k]) begin
                m_busy[k] = 1'b0;
            end
        end
    endtask

    task automatic compare_all();
        check("ack", DW'(reg2ip_ack), DW'(m_busy));
        check("ch_data", ch_data_o, m_data);
        check("ip2reg_data", ip2reg_data, m_snap);
        check("ip2reg_en", DW'(ip2reg_en), DW'(m_en));
    endtask

    task automatic step();
        @(posedge clk_i);
        model_edge();
        #1;
        compare_all();
    endtask

    typedef struct {
        logic [NUM_CH-1:0] req;
        logic [DW-1:0]     data;
        logic [NUM_CH-1:0] exp_ack;
        logic [DW-1:0]     exp_data;
    } vec_t;

    vec_t vecs [13];

    initial begin
        // Words are listed {word2, word1, word0}.
        vecs[0]  = '{req: 3'b010, data: {32'h0, 32'hDEADBEEF, 32'h0}, exp_ack: 3'b010, exp_data: {32'h0, 32'hDEADBEEF, 32'h0}};
        vecs[1]  = '{req: 3'b010, data: {32'h0, 32'h1234, 32'h0},     exp_ack: 3'b010, exp_data: {32'h0, 32'hDEADBEEF, 32'h0}};
        vecs[2]  = '{req: 3'b010, data: {32'h0, 32'h1234, 32'h0},     exp_ack: 3'b010, exp_data: {32'h0, 32'hDEADBEEF, 32'h0}};
        vecs[3]  = '{req: 3'b010, data: {32'h0, 32'h1234, 32'h0},     exp_ack: 3'b010, exp_data: {32'h0, 32'hDEADBEEF, 32'h0}};
        vecs[4]  = '{req: 3'b010, data: {32'h0, 32'h1234, 32'h0},     exp_ack: 3'b010, exp_data: {32'h0, 32'hDEADBEEF, 32'h0}};
        vecs[5]  = '{req: 3'b000, data: {32'h0, 32'h0, 32'h0},        exp_ack: 3'b000, exp_data: {32'h0, 32'hDEADBEEF, 32'h0}};
        vecs[6]  = '{req: 3'b111, data: {32'h3, 32'h2, 32'h1},        exp_ack: 3'b111, exp_data: {32'h3, 32'h2, 32'h1}};
        vecs[7]  = '{req: 3'b111, data: {32'h9, 32'h9, 32'h9},        exp_ack: 3'b111, exp_data: {32'h3, 32'h2, 32'h1}};
        vecs[8]  = '{req: 3'b000, data: {32'h0, 32'h0, 32'h0},        exp_ack: 3'b000, exp_data: {32'h3, 32'h2, 32'h1}};
        vecs[9]  = '{req: 3'b010, data: {32'h0, 32'h5, 32'h0},        exp_ack: 3'b010, exp_data: {32'h3, 32'h5, 32'h1}};
        vecs[10] = '{req: 3'b000, data: {32'h0, 32'h0, 32'h0},        exp_ack: 3'b000, exp_data: {32'h3, 32'h5, 32'h1}};
        vecs[11] = '{req: 3'b100, data: {32'hCAFE, 32'h0, 32'h0},     exp_ack: 3'b100, exp_data: {32'hCAFE, 32'h5, 32'h1}};
        vecs[12] = '{req: 3'b000, data: {32'h0, 32'h0, 32'h0},        exp_ack: 3'b000, exp_data: {32'hCAFE, 32'h5, 32'h1}};

        model_reset();
        #2;
        check("reset ack", DW'(reg2ip_ack), '0);
        check("reset ch_data", ch_data_o, '0);
        check("reset ip2reg_data", ip2reg_data, '0);
        check("reset ip2reg_en", DW'(ip2reg_en), '0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // First automatic snapshot lands on edge SNAP_PERIOD with all-zero status.
        for (int i = 1; i <= SNAP_PERIOD; i++) step();
        check("first auto snap en", DW'(ip2reg_en), '0);

        for (int i = 0; i < 13; i++) begin
            reg2ip_req  = vecs[i].req;
            reg2ip_data = vecs[i].data;
            step();
            check($sformatf("vec%0d ack", i), DW'(reg2ip_ack), DW'(vecs[i].exp_ack));
            check($sformatf("vec%0d ch_data", i), ch_data_o, vecs[i].exp_data);
        end

`ifndef CUSTOM_IP_REGBANK_LOOPBACK_EN
        hw_status_i = {32'h48D0, 32'h0, 32'h0};
        snap_req_i  = 1'b1;
        step();
        check("manual snap en", DW'(ip2reg_en), DW'(3'b100));
        check("manual snap word2", DW'(ip2reg_data[2*CH_WIDTH +: CH_WIDTH]), DW'(32'h48D0));
        step();
        check("repeat snap en", DW'(ip2reg_en), '0);
        snap_req_i = 1'b0;

        // Manual strobe on the same edge as the automatic trigger.
        while (((cyc + 1) % SNAP_PERIOD) != 0) step();
        hw_status_i[0 +: CH_WIDTH] = 32'h11;
        snap_req_i = 1'b1;
        step();
        check("coincident snap en", DW'(ip2reg_en), DW'(3'b001));
        snap_req_i = 1'b0;
        hw_status_i[CH_WIDTH +: CH_WIDTH] = 32'h22;
        for (int i = 1; i <= SNAP_PERIOD; i++) begin
            step();
            check($sformatf("post-coincident en%0d", i), DW'(ip2reg_en),
                  (i == SNAP_PERIOD) ? DW'(3'b010) : '0);
        end
`else
        // Start right after an automatic snapshot so nothing intervenes before the manual one.
        while ((cyc % SNAP_PERIOD) != 0) step();
        reg2ip_req  = 3'b001;
        reg2ip_data = {32'h0, 32'h0, 32'hA5A5A5A5};
        step();
        reg2ip_req = 3'b000;
        step();
        snap_req_i = 1'b1;
        step();
        snap_req_i = 1'b0;
        check("loopback word0", DW'(ip2reg_data[0 +: CH_WIDTH]), DW'(32'hA5A5A5A5));
        check("loopback en", DW'(ip2reg_en), DW'(3'b001));
`endif

        // Reset in the middle of a handshake, request held across it.
        reg2ip_req  = 3'b010;
        reg2ip_data = {32'h0, 32'h77, 32'h0};
        step();
        check("pre-reset ack", DW'(reg2ip_ack), DW'(3'b010));
        #2;
        rst_ni = 1'b0;
        #1;
        check("async reset ack", DW'(reg2ip_ack), '0);
        check("async reset ch_data", ch_data_o, '0);
        model_reset();
        @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        step();
        check("recapture ack", DW'(reg2ip_ack), DW'(3'b010));
        check("recapture word1", DW'(ch_data_o[CH_WIDTH +: CH_WIDTH]), DW'(32'h77));
        reg2ip_req = '0;
        step();

        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if ($urandom_range(0, 3) == 0) reg2ip_req[k] = ~reg2ip_req[k];
                reg2ip_data[k*CH_WIDTH +: CH_WIDTH] = $urandom;
            end
            if ($urandom_range(0, 3) == 0)
                hw_status_i[$urandom_range(0, NUM_CH - 1)*CH_WIDTH +: CH_WIDTH] = $urandom;
            snap_req_i = ($urandom_range(0, 5) == 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
